bank_write_dispatcher: RTL and testbench

- Write-side counterpart of the 16-bank output select path.
- Accepts a valid/ready stream of `D_width` coefficients and distributes each word to one of 16 memory banks.
- Generates a one-hot per-bank write enable, a shared row address and broadcast write data, one registered cycle after acceptance.
- Supports linear or skewed (conflict-free) bank mapping, so the 16:1 read mux can later fetch a full row or a full column without conflicts.

---
 rtl/bank_write_dispatcher_if.sv | 35 +++
 rtl/bank_write_dispatcher.sv | 125 ++++++++++++
 tb/tb_bank_write_dispatcher.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bank_write_dispatcher_if.sv
// ---------------------------------------------------------------------------
// bank_write_dispatcher_if
// Bundles the load-control, input-stream and bank-write signals of the
// 16-bank write dispatcher.
//   start, skew_en       : load control (pulse + bank mapping select)
//   in_valid/in_data     : input word stream, in_ready is the backpressure
//   Q_in/wr_addr/wr_en   : broadcast data, shared row address, one-hot bank WE
//   busy/done            : transaction status
// master = stream producer / controller, slave = dispatcher.
// ---------------------------------------------------------------------------
interface bank_write_dispatcher_if #(
    parameter int DATA_W     = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                  start;
    logic                  skew_en;
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_ready;
    logic [DATA_W-1:0]     Q_in;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [15:0]           wr_en;
    logic                  busy;
    logic                  done;

    modport master (
        output start, skew_en, in_valid, in_data,
        input  in_ready, Q_in, wr_addr, wr_en, busy, done
    );

    modport slave (
        input  start, skew_en, in_valid, in_data,
        output in_ready, Q_in, wr_addr, wr_en, busy, done
    );
endinterface

// File: rtl/bank_write_dispatcher.sv
// ---------------------------------------------------------------------------
// bank_write_dispatcher
// Distributes a stream of N_WORDS coefficients over 16 memory banks. Each
// accepted word produces, one cycle later, a one-hot bank write enable, the
// shared row address and the broadcast write data. With skew enabled the
// bank is rotated by the row number so that both a full row and a full
// column can later be read without bank conflicts.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : bank_write_dispatcher_if.slave (start, skew_en, in_valid, in_data,
//          in_ready, Q_in, wr_addr, wr_en, busy, done)
// ---------------------------------------------------------------------------
module bank_write_dispatcher #(
    parameter int N_WORDS    = 1024,
    parameter int ADDR_WIDTH = 6,
    parameter int IDX_WIDTH  = 10,
    parameter int DATA_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    bank_write_dispatcher_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic                  r_skew_q;
    logic                  r_in_ready;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_W-1:0]     r_q_in;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [15:0]           r_wr_en;

    logic                  w_accept;
    logic [IDX_WIDTH-5:0]  w_row;
    logic [3:0]            w_col;
    logic [3:0]            w_bank;

    // Rotating the column by the low row bits places consecutive rows on
    // shifted banks; the 4-bit add wraps modulo 16.
    function automatic logic [3:0] map_bank(input logic [3:0] col,
                                            input logic [3:0] row_lsb,
                                            input logic       skew);
        return skew ? (col + row_lsb) : col;
    endfunction

    // r_in_ready is high exactly in LOAD, so it doubles as the state qualifier
    assign w_accept = r_in_ready & bus.in_valid;
    assign w_row    = r_idx[IDX_WIDTH-1:4];
    assign w_col    = r_idx[3:0];
    assign w_bank   = map_bank(w_col, w_row[3:0], r_skew_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_skew_q   <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_q_in     <= '0;
            r_wr_addr  <= '0;
            r_wr_en    <= '0;
        end else begin
            // write enable and done are single-cycle pulses unless re-asserted
            r_wr_en <= '0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_skew_q   <= bus.skew_en;
                        r_idx      <= '0;
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_q_in    <= bus.in_data;
                        r_wr_addr <= ADDR_WIDTH'(w_row);
                        r_wr_en   <= 16'h0001 << w_bank;
                        if (r_idx == IDX_WIDTH'(N_WORDS - 1)) begin
                            r_idx      <= '0;
                            r_state    <= S_FLUSH;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_idx <= r_idx + IDX_WIDTH'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    // the last write is on the outputs during this cycle
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.Q_in     = r_q_in;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_en    = r_wr_en;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_bank_write_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_bank_write_dispatcher
// Directed bench for the 16-bank write dispatcher: linear and skewed loads,
// input bubbles, ignored controls, mid-load reset and back-to-back loads.
// Expected writes are queued when a word is driven and popped when the DUT
// presents the write one cycle later.
// ---------------------------------------------------------------------------
module tb_bank_write_dispatcher;

    localparam int N_WORDS = 1024;

    typedef struct packed {
        logic [15:0] en;
        logic [5:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    int   m_idx;
    bit   m_skew;
    exp_t q_exp[$];

    bank_write_dispatcher_if #(.DATA_W(16), .ADDR_WIDTH(6)) bif ();

    bank_write_dispatcher #(
        .N_WORDS   (N_WORDS),
        .ADDR_WIDTH(6),
        .IDX_WIDTH (10),
        .DATA_W    (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_en(input int idx, input bit skew);
        int b;
        b = skew ? (((idx % 16) + ((idx / 16) % 16)) % 16) : (idx % 16);
        return 16'h0001 << b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of the input stream while the dispatcher is loading.
    task automatic word(input logic v, input logic [15:0] d);
        exp_t e;
        bif.in_valid = v;
        bif.in_data  = d;
        @(posedge clk);
        if (v) begin
            e.en   = exp_en(m_idx, m_skew);
            e.addr = 6'(m_idx / 16);
            e.data = d;
            q_exp.push_back(e);
            m_idx++;
        end
        #1;
        if (v) begin
            e = q_exp.pop_front();
            chk("wr_en", 32'(bif.wr_en), 32'(e.en));
            chk("wr_addr", 32'(bif.wr_addr), 32'(e.addr));
            chk("Q_in", 32'(bif.Q_in), 32'(e.data));
        end else begin
            chk("wr_en_gap", 32'(bif.wr_en), 32'h0);
        end
        chk("done_early", 32'(bif.done), 32'h0);
        bif.in_valid = 1'b0;
    endtask

    task automatic do_start(input bit skew);
        bif.start   = 1'b1;
        bif.skew_en = skew;
        tick();
        bif.start   = 1'b0;
        bif.skew_en = ~skew;    // mapping must be the one latched at start
        m_idx  = 0;
        m_skew = skew;
        chk("start_busy", 32'(bif.busy), 32'h1);
        chk("start_ready", 32'(bif.in_ready), 32'h1);
        chk("start_wr_en", 32'(bif.wr_en), 32'h0);
    endtask

    // After the final accepted word: FLUSH, DONE, back to IDLE.
    task automatic finish_load();
        chk("flush_ready", 32'(bif.in_ready), 32'h0);
        chk("flush_busy", 32'(bif.busy), 32'h1);
        tick();
        chk("done_pulse", 32'(bif.done), 32'h1);
        chk("done_wr_en", 32'(bif.wr_en), 32'h0);
        chk("done_busy", 32'(bif.busy), 32'h1);
        tick();
        chk("idle_done", 32'(bif.done), 32'h0);
        chk("idle_busy", 32'(bif.busy), 32'h0);
        chk("idle_ready", 32'(bif.in_ready), 32'h0);
    endtask

    initial begin
        n_checks     = 0;
        n_err        = 0;
        m_idx        = 0;
        m_skew       = 1'b0;
        rst          = 1'b1;
        bif.start    = 1'b0;
        bif.skew_en  = 1'b0;
        bif.in_valid = 1'b0;
        bif.in_data  = '0;
        tick();
        tick();
        chk("rst_ready", 32'(bif.in_ready), 32'h0);
        chk("rst_wr_en", 32'(bif.wr_en), 32'h0);
        chk("rst_busy", 32'(bif.busy), 32'h0);
        chk("rst_done", 32'(bif.done), 32'h0);
        chk("rst_Q_in", 32'(bif.Q_in), 32'h0);
        chk("rst_wr_addr", 32'(bif.wr_addr), 32'h0);
        rst = 1'b0;

        // in_valid while idle is ignored
        bif.in_valid = 1'b1;
        bif.in_data  = 16'hDEAD;
        tick();
        chk("idle_valid_ready", 32'(bif.in_ready), 32'h0);
        chk("idle_valid_wr_en", 32'(bif.wr_en), 32'h0);
        chk("idle_valid_busy", 32'(bif.busy), 32'h0);
        bif.in_valid = 1'b0;

        // Linear load, with a stray start at index 500
        do_start(1'b0);
        for (int i = 0; i < N_WORDS; i++) begin
            if (i == 500) bif.start = 1'b1;
            word(1'b1, 16'(i) ^ 16'hA5A5);
            bif.start = 1'b0;
            if (i == 17) begin
                chk("lin_w17_en", 32'(bif.wr_en), 32'h0002);
                chk("lin_w17_addr", 32'(bif.wr_addr), 32'd1);
            end
            if (i == 500) chk("midstart_busy", 32'(bif.busy), 32'h1);
        end
        finish_load();

        // Back-to-back skewed load, starting with bubbles
        do_start(1'b1);
        word(1'b1, 16'h1000);
        word(1'b0, 16'h0000);
        word(1'b0, 16'h0000);
        word(1'b1, 16'h1001);
        chk("bubble_busy", 32'(bif.busy), 32'h1);
        chk("bubble_ready", 32'(bif.in_ready), 32'h1);
        for (int i = 2; i < N_WORDS; i++) begin
            word(1'b1, 16'h1000 + 16'(i));
            if (i == 35) begin
                chk("skew_w35_en", 32'(bif.wr_en), 32'h0020);
                chk("skew_w35_addr", 32'(bif.wr_addr), 32'd2);
            end
            if (i == 1023) begin
                chk("skew_w1023_en", 32'(bif.wr_en), 32'h4000);
                chk("skew_w1023_addr", 32'(bif.wr_addr), 32'd63);
            end
        end
        finish_load();

        // Reset in the middle of a load
        do_start(1'b1);
        for (int i = 0; i < 300; i++) word(1'b1, 16'h2000 + 16'(i));
        rst          = 1'b1;
        bif.in_valid = 1'b1;
        bif.in_data  = 16'hBEEF;
        tick();
        chk("mrst_wr_en", 32'(bif.wr_en), 32'h0);
        chk("mrst_busy", 32'(bif.busy), 32'h0);
        chk("mrst_ready", 32'(bif.in_ready), 32'h0);
        chk("mrst_Q_in", 32'(bif.Q_in), 32'h0);
        chk("mrst_wr_addr", 32'(bif.wr_addr), 32'h0);
        bif.in_valid = 1'b0;

        // start together with reset: reset wins
        bif.start = 1'b1;
        tick();
        rst       = 1'b0;
        bif.start = 1'b0;
        tick();
        chk("rststart_busy", 32'(bif.busy), 32'h0);
        chk("rststart_ready", 32'(bif.in_ready), 32'h0);

        // fresh load begins at bank 0, row 0
        do_start(1'b0);
        word(1'b1, 16'h3333);
        chk("restart_en", 32'(bif.wr_en), 32'h0001);
        chk("restart_addr", 32'(bif.wr_addr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
